bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Parametrised N-requester to single-bus-master adapter. Successor to the two-source (instruction fetch / data) bus adapter.
- Generalises requester count, data width and arbitration mode.
- Adds round-robin fairness, a bus timeout with error reporting, and an explicit per-requester ready/error return.
- Sits between the core's fetch/data/DMA requesters and the system bus master port.

Parameters:
- N_REQ, 2, number of requester ports (1..8).
- XLEN, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- ARB_MODE, 0, arbitration mode: 0 = fixed priority (index 0 highest), 1 = round-robin.
- TIMEOUT, 0, BUSY cycles without ack before an error completion; 0 disables the timeout.
- WALIGN, 2, number of low address bits cleared on writes.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req  in  N_REQ  per-requester request; held until that requester's o_ready.
- i_wr_en  in  N_REQ  per-requester write (1) / read (0).
- i_addr  in  N_REQ*XLEN  packed addresses; requester k occupies slice [k*XLEN +: XLEN].
- i_wdata  in  N_REQ*DATA_W  packed write data.
- i_byte_en  in  N_REQ*DATA_W/8  packed byte enables.
- o_ready  out  N_REQ  one-cycle completion pulse to the granted requester.
- o_err  out  N_REQ  one-cycle pulse, coincident with o_ready, on timeout.
- o_rdata  out  DATA_W  read data, valid when o_ready is high.
- o_bus_en  out  1  bus transaction active.
- o_bus_wr_en  out  1  bus write.
- o_bus_addr  out  XLEN  bus address.
- o_bus_wdata  out  DATA_W  bus write data.
- o_bus_byte_en  out  DATA_W/8  bus byte enables.
- i_bus_rd_data  in  DATA_W  bus read data.
- i_bus_ack  in  1  bus completion.

Behaviour:
- Reset: state IDLE; all o_bus_* = 0; o_ready = 0; o_err = 0; o_rdata = 0; timeout counter = 0; round-robin pointer = 0 (points to requester 0 as highest priority).
- States: IDLE, BUSY.
- IDLE, any i_req high:
  - Select grant g. Fixed mode: lowest set index. RR mode: first set index at or after the pointer, wrapping.
  - At the next edge: register o_bus_en=1, o_bus_wr_en, o_bus_addr, o_bus_wdata, o_bus_byte_en from slice g; store g; go BUSY.
  - Write address has bits [WALIGN-1:0] forced to 0; read address passes unmodified.
- IDLE, no request: o_bus_en stays 0. i_bus_ack is ignored in IDLE.
- BUSY: bus fields held constant; counter increments each cycle.
- BUSY, i_bus_ack=1 (combinational completion):
  - o_ready[g]=1 and o_rdata=i_bus_rd_data in the same cycle.
  - At the edge: o_bus_en cleared, counter cleared, state to IDLE.
  - RR mode: pointer set to (g+1) mod N_REQ.
- BUSY, TIMEOUT!=0 and counter==TIMEOUT-1 with no ack:
  - o_ready[g]=1, o_err[g]=1, o_rdata=0.
  - Same exit actions as an ack completion.
- Ack and timeout in the same cycle: ack wins; o_err stays 0.
- Latency: request seen in cycle t → o_bus_en high at t+1 → earliest o_ready at t+1 on a same-cycle ack.
- Turnaround: at least one IDLE cycle between transactions, so o_bus_en drops for at least one cycle. The requester must drop or update i_req in the cycle after o_ready.
- Requester deasserts i_req mid-BUSY: the transaction still completes on the bus and o_ready[g] still pulses; no abort.
- Requester inputs changing during BUSY have no effect.
- o_ready and o_err are zero on every bit except g.
- Reset asserted mid-BUSY: immediate return to reset values; any ack that arrives afterwards is ignored.
- N_REQ=1: arbitration is degenerate; behaviour is otherwise identical.

Decomposition:
- Package bus_arb_pkg holds:
  - state enum (IDLE, BUSY);
  - ARB_FIXED / ARB_RR constants;
  - width function for the grant index (clog2 with a minimum of 1).
- Sub-module rr_arbiter (parameters N_REQ, ARB_MODE):
  - inputs: request vector, pointer;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- The FSM, bus registers, counter and pointer live in bus_arbiter.

Test Plan:
1. N_REQ=2, fixed mode. Both requesters read at once (addr0=0x100, addr1=0x200); bus acks one cycle after o_bus_en with data 0xDEADBEEF. Required: bus addr 0x100 first; o_ready=2'b01 with o_rdata=0xDEADBEEF; one idle cycle; then addr 0x200 and o_ready=2'b10.
2. N_REQ=3, RR mode, all three requesting continuously. Required: grant order 0,1,2,0,1,2; each requester gets exactly 2 completions in 6 transactions.
3. Write from requester 1 with addr 0x1003, byte_en 4'b1000, wdata 0x11223344. Required: o_bus_addr=0x1000, o_bus_wr_en=1, o_bus_byte_en=4'b1000, o_bus_wdata=0x11223344.
4. TIMEOUT=4, ack never asserted. Required: o_bus_en high for exactly 4 cycles; o_ready[g] and o_err[g] pulse in cycle 4; o_rdata=0; then IDLE. Repeat with ack in cycle 4: o_err stays 0.
5. Reset pulse during BUSY; ack arrives two cycles later. Required: all outputs return to 0 immediately and no o_ready pulse occurs.
6. Requester drops i_req one cycle into BUSY; ack arrives 3 cycles later. Required: o_ready[g] still pulses once; the next grant goes to the remaining requester.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types, constants and helpers for the N-requester bus arbiter.
package bus_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: fixed priority (index 0 highest) or round-robin from a pointer.
module rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int ARB_MODE = ARB_FIXED,
    localparam int IW      = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_idx
);

    logic          w_hit;
    logic          w_hit_hi;
    logic [IW-1:0] w_idx_lo;
    logic [IW-1:0] w_idx_hi;

    // Round-robin: lowest request at or above the pointer, else wrap to lowest overall.
    always_comb begin
        w_hit    = 1'b0;
        w_hit_hi = 1'b0;
        w_idx_lo = '0;
        w_idx_hi = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_hit    = 1'b1;
                w_idx_lo = IW'(i);
            end
            if (i_req[i] && (ARB_MODE == ARB_RR) && (i >= int'(i_ptr))) begin
                w_hit_hi = 1'b1;
                w_idx_hi = IW'(i);
            end
        end
        o_idx   = w_hit_hi ? w_idx_hi : w_idx_lo;
        o_grant = w_hit ? (N_REQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// N-requester to single bus master adapter with fixed/round-robin arbitration and bus timeout.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int XLEN     = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int TIMEOUT  = 0,
    parameter int WALIGN   = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_wr_en,
    input  logic [N_REQ*XLEN-1:0]     i_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_wdata,
    input  logic [N_REQ*DATA_W/8-1:0] i_byte_en,
    output logic [N_REQ-1:0]          o_ready,
    output logic [N_REQ-1:0]          o_err,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_bus_en,
    output logic                      o_bus_wr_en,
    output logic [XLEN-1:0]           o_bus_addr,
    output logic [DATA_W-1:0]         o_bus_wdata,
    output logic [DATA_W/8-1:0]       o_bus_byte_en,
    input  logic [DATA_W-1:0]         i_bus_rd_data,
    input  logic                      i_bus_ack
);

    localparam int IW = idx_w(N_REQ);
    localparam int BW = DATA_W / 8;
    localparam int CW = idx_w(TIMEOUT);
    localparam logic [CW-1:0]   TO_LAST    = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << WALIGN) - XLEN'(1));

    state_t           r_state;
    state_t           w_state_d;
    logic             r_bus_en;
    logic             r_bus_wr_en;
    logic [XLEN-1:0]  r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [BW-1:0]    r_bus_byte_en;
    logic [IW-1:0]    r_gnt_idx;
    logic [N_REQ-1:0] r_gnt_oh;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_ptr;

    logic [N_REQ-1:0] w_gnt_oh;
    logic [IW-1:0]    w_gnt_idx;
    logic             w_start;
    logic             w_ack_done;
    logic             w_to_done;
    logic             w_done;
    logic             w_sel_wr;
    logic [XLEN-1:0]  w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [BW-1:0]    w_sel_be;
    logic [IW-1:0]    w_ptr_next;

    rr_arbiter #(
        .N_REQ    (N_REQ),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt_oh),
        .o_idx   (w_gnt_idx)
    );

    assign w_sel_wr    = i_wr_en[w_gnt_idx];
    assign w_sel_addr  = i_addr[int'(w_gnt_idx) * XLEN +: XLEN];
    assign w_sel_wdata = i_wdata[int'(w_gnt_idx) * DATA_W +: DATA_W];
    assign w_sel_be    = i_byte_en[int'(w_gnt_idx) * BW +: BW];
    assign w_ptr_next  = (int'(r_gnt_idx) == N_REQ - 1) ? '0 : r_gnt_idx + IW'(1);

    always_comb begin
        w_state_d  = r_state;
        w_start    = 1'b0;
        w_ack_done = 1'b0;
        w_to_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|i_req) begin
                    w_start   = 1'b1;
                    w_state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // An ack in the timeout cycle takes precedence over the error completion.
                if (i_bus_ack) begin
                    w_ack_done = 1'b1;
                    w_state_d  = ST_IDLE;
                end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
                    w_to_done = 1'b1;
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    assign w_done  = w_ack_done | w_to_done;
    assign o_ready = w_done ? r_gnt_oh : '0;
    assign o_err   = w_to_done ? r_gnt_oh : '0;
    assign o_rdata = w_ack_done ? i_bus_rd_data : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_bus_en      <= 1'b0;
            r_bus_wr_en   <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_bus_byte_en <= '0;
            r_gnt_idx     <= '0;
            r_gnt_oh      <= '0;
            r_cnt         <= '0;
            r_ptr         <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_start) begin
                r_bus_en      <= 1'b1;
                r_bus_wr_en   <= w_sel_wr;
                r_bus_addr    <= w_sel_wr ? (w_sel_addr & ALIGN_MASK) : w_sel_addr;
                r_bus_wdata   <= w_sel_wdata;
                r_bus_byte_en <= w_sel_be;
                r_gnt_idx     <= w_gnt_idx;
                r_gnt_oh      <= w_gnt_oh;
                r_cnt         <= '0;
            end else if (w_done) begin
                r_bus_en <= 1'b0;
                r_cnt    <= '0;
                if (ARB_MODE == ARB_RR) begin
                    r_ptr <= w_ptr_next;
                end
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_bus_en      = r_bus_en;
    assign o_bus_wr_en   = r_bus_wr_en;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_wdata   = r_bus_wdata;
    assign o_bus_byte_en = r_bus_byte_en;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: three arbiter configurations (fixed, round-robin, timeout) with a completion scoreboard.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        logic [7:0]  ready;
        logic [7:0]  err;
        logic [31:0] rdata;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // DUT A: 2 requesters, fixed priority, no timeout
    logic [1:0]  a_req, a_wr, a_ready, a_err;
    logic [63:0] a_addr, a_wdata;
    logic [7:0]  a_be;
    logic [31:0] a_rdata, a_bus_addr, a_bus_wdata, a_bus_rd;
    logic        a_bus_en, a_bus_wr, a_ack;
    logic [3:0]  a_bus_be;

    // DUT B: 3 requesters, round-robin
    logic [2:0]  b_req, b_wr, b_ready, b_err;
    logic [95:0] b_addr, b_wdata;
    logic [11:0] b_be;
    logic [31:0] b_rdata, b_bus_addr, b_bus_wdata, b_bus_rd;
    logic        b_bus_en, b_bus_wr, b_ack;
    logic [3:0]  b_bus_be;

    // DUT C: 2 requesters, fixed priority, TIMEOUT=4
    logic [1:0]  c_req, c_wr, c_ready, c_err;
    logic [63:0] c_addr, c_wdata;
    logic [7:0]  c_be;
    logic [31:0] c_rdata, c_bus_addr, c_bus_wdata, c_bus_rd;
    logic        c_bus_en, c_bus_wr, c_ack;
    logic [3:0]  c_bus_be;

    bus_arbiter #(.N_REQ(2), .XLEN(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(0), .WALIGN(2)) u_a (
        .i_clk(clk), .i_rst(rst), .i_req(a_req), .i_wr_en(a_wr), .i_addr(a_addr),
        .i_wdata(a_wdata), .i_byte_en(a_be), .o_ready(a_ready), .o_err(a_err),
        .o_rdata(a_rdata), .o_bus_en(a_bus_en), .o_bus_wr_en(a_bus_wr), .o_bus_addr(a_bus_addr),
        .o_bus_wdata(a_bus_wdata), .o_bus_byte_en(a_bus_be), .i_bus_rd_data(a_bus_rd),
        .i_bus_ack(a_ack)
    );

    bus_arbiter #(.N_REQ(3), .XLEN(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(0), .WALIGN(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_req(b_req), .i_wr_en(b_wr), .i_addr(b_addr),
        .i_wdata(b_wdata), .i_byte_en(b_be), .o_ready(b_ready), .o_err(b_err),
        .o_rdata(b_rdata), .o_bus_en(b_bus_en), .o_bus_wr_en(b_bus_wr), .o_bus_addr(b_bus_addr),
        .o_bus_wdata(b_bus_wdata), .o_bus_byte_en(b_bus_be), .i_bus_rd_data(b_bus_rd),
        .i_bus_ack(b_ack)
    );

    bus_arbiter #(.N_REQ(2), .XLEN(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(4), .WALIGN(2)) u_c (
        .i_clk(clk), .i_rst(rst), .i_req(c_req), .i_wr_en(c_wr), .i_addr(c_addr),
        .i_wdata(c_wdata), .i_byte_en(c_be), .o_ready(c_ready), .o_err(c_err),
        .o_rdata(c_rdata), .o_bus_en(c_bus_en), .o_bus_wr_en(c_bus_wr), .o_bus_addr(c_bus_addr),
        .o_bus_wdata(c_bus_wdata), .o_bus_byte_en(c_bus_be), .i_bus_rd_data(c_bus_rd),
        .i_bus_ack(c_ack)
    );

    int a_rc[2];
    int b_rc[3];
    int c_en_cycles = 0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) if (a_ready[k]) a_rc[k] <= a_rc[k] + 1;
    end
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) if (b_ready[k]) b_rc[k] <= b_rc[k] + 1;
    end
    always @(negedge clk) begin
        if (c_bus_en) c_en_cycles <= c_en_cycles + 1;
    end

    function automatic logic [7:0] f_rdy(input int d);
        case (d)
            0:       return {6'b0, a_ready};
            1:       return {5'b0, b_ready};
            default: return {6'b0, c_ready};
        endcase
    endfunction

    function automatic logic [7:0] f_err(input int d);
        case (d)
            0:       return {6'b0, a_err};
            1:       return {5'b0, b_err};
            default: return {6'b0, c_err};
        endcase
    endfunction

    function automatic logic [31:0] f_rdata(input int d);
        case (d)
            0:       return a_rdata;
            1:       return b_rdata;
            default: return c_rdata;
        endcase
    endfunction

    function automatic logic [31:0] f_addr(input int d);
        case (d)
            0:       return a_bus_addr;
            1:       return b_bus_addr;
            default: return c_bus_addr;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] r, input logic [7:0] e,
                        input logic [31:0] rd, input logic [31:0] ad);
        exp_t x;
        x.dut   = d;
        x.ready = r;
        x.err   = e;
        x.rdata = rd;
        x.addr  = ad;
        sb.push_back(x);
    endtask

    // Called just after a negedge; polls o_ready for up to max cycles, then pops and compares.
    task automatic wait_ready(input int d, input int max, output int cyc);
        logic seen;
        exp_t e;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < max && !seen; i++) begin
            #1;
            if (f_rdy(d) != 8'h0) begin
                seen = 1'b1;
                cyc  = i + 1;
            end else begin
                @(negedge clk);
            end
        end
        chk("ready_seen", seen, 1);
        if (seen) begin
            chk("sb_avail", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_dut", d, e.dut);
                chk("sb_ready", f_rdy(d), e.ready);
                chk("sb_err", f_err(d), e.err);
                chk("sb_rdata", f_rdata(d), e.rdata);
                chk("sb_bus_addr", f_addr(d), e.addr);
            end
        end
    endtask

    initial begin
        int n;
        int r0, r1, en0;
        rst = 1'b1;
        a_req = '0; a_wr = '0; a_addr = '0; a_wdata = '0; a_be = '0; a_bus_rd = '0; a_ack = 1'b0;
        b_req = '0; b_wr = '0; b_addr = '0; b_wdata = '0; b_be = '0; b_bus_rd = '0; b_ack = 1'b0;
        c_req = '0; c_wr = '0; c_addr = '0; c_wdata = '0; c_be = '0; c_bus_rd = '0; c_ack = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_a_bus_en", a_bus_en, 0);
        chk("rst_a_bus_addr", a_bus_addr, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_bus_en", b_bus_en, 0);
        chk("rst_c_err", c_err, 0);

        // Ack while idle must be ignored
        rst = 1'b0;
        a_ack = 1'b1;
        a_bus_rd = 32'h12345678;
        #1 chk("idle_ack_ready", a_ready, 0);
        chk("idle_ack_rdata", a_rdata, 0);
        @(negedge clk);
        chk("idle_bus_en", a_bus_en, 0);
        a_ack = 1'b0;

        // Fixed priority: both read, requester 0 first
        a_addr = {32'h0000_0200, 32'h0000_0100};
        a_req = 2'b11;
        a_bus_rd = 32'hDEAD_BEEF;
        push(0, 8'h01, 8'h00, 32'hDEAD_BEEF, 32'h100);
        push(0, 8'h02, 8'h00, 32'hDEAD_BEEF, 32'h200);
        @(negedge clk);
        chk("t1_bus_en", a_bus_en, 1);
        chk("t1_addr0", a_bus_addr, 32'h100);
        chk("t1_wr", a_bus_wr, 0);
        @(negedge clk);
        a_ack = 1'b1;
        wait_ready(0, 2, n);
        a_req[0] = 1'b0;
        @(negedge clk);
        a_ack = 1'b0;
        chk("t1_turnaround", a_bus_en, 0);
        @(negedge clk);
        chk("t1_bus_en1", a_bus_en, 1);
        chk("t1_addr1", a_bus_addr, 32'h200);
        a_ack = 1'b1;
        wait_ready(0, 2, n);
        a_req = '0;
        @(negedge clk);
        a_ack = 1'b0;

        // Round-robin with three continuous requesters
        b_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        b_bus_rd = 32'hA5A5_0000;
        b_ack = 1'b1;
        b_req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            push(1, 8'(1 << (i % 3)), 8'h00, 32'hA5A5_0000, 32'(32'h1000 * (i % 3 + 1)));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wait_ready(1, 3, n);
        end
        b_req = '0;
        @(negedge clk);
        b_ack = 1'b0;
        chk("t2_cnt0", b_rc[0], 2);
        chk("t2_cnt1", b_rc[1], 2);
        chk("t2_cnt2", b_rc[2], 2);

        // Write from requester 1 with misaligned address
        a_addr = {32'h0000_1003, 32'h0};
        a_wr = 2'b10;
        a_be = {4'b1000, 4'b0000};
        a_wdata = {32'h1122_3344, 32'h0};
        a_bus_rd = 32'h0000_0055;
        a_req = 2'b10;
        push(0, 8'h02, 8'h00, 32'h55, 32'h1000);
        @(negedge clk);
        chk("t3_addr", a_bus_addr, 32'h1000);
        chk("t3_wr", a_bus_wr, 1);
        chk("t3_be", a_bus_be, 4'b1000);
        chk("t3_wdata", a_bus_wdata, 32'h1122_3344);
        a_ack = 1'b1;
        wait_ready(0, 2, n);
        a_req = '0;
        a_wr = '0;
        @(negedge clk);
        a_ack = 1'b0;

        // Misaligned read passes the address unmodified
        a_addr = {32'h0, 32'h0000_0103};
        a_req = 2'b01;
        push(0, 8'h01, 8'h00, 32'h55, 32'h103);
        @(negedge clk);
        chk("t3_rd_addr", a_bus_addr, 32'h103);
        chk("t3_rd_wr", a_bus_wr, 0);
        a_ack = 1'b1;
        wait_ready(0, 2, n);
        a_req = '0;
        @(negedge clk);
        a_ack = 1'b0;

        // Timeout with no ack
        c_addr = {32'h0, 32'h0000_0040};
        c_bus_rd = 32'hFFFF_FFFF;
        en0 = c_en_cycles;
        c_req = 2'b01;
        push(2, 8'h01, 8'h01, 32'h0, 32'h40);
        @(negedge clk);
        wait_ready(2, 6, n);
        chk("t4_to_cycle", n, 4);
        c_req = '0;
        @(negedge clk);
        #1;
        chk("t4_idle", c_bus_en, 0);
        chk("t4_en_cycles", c_en_cycles - en0, 4);

        // Ack in the timeout cycle wins
        c_bus_rd = 32'h0BAD_F00D;
        c_req = 2'b01;
        push(2, 8'h01, 8'h00, 32'h0BAD_F00D, 32'h40);
        repeat (4) @(negedge clk);
        c_ack = 1'b1;
        wait_ready(2, 1, n);
        c_req = '0;
        @(negedge clk);
        c_ack = 1'b0;
        chk("t4_ack_idle", c_bus_en, 0);

        // Reset during BUSY, late ack ignored
        a_addr = {32'h0, 32'h0000_0300};
        a_req = 2'b01;
        r0 = a_rc[0];
        @(negedge clk);
        chk("t5_busy", a_bus_en, 1);
        @(negedge clk);
        rst = 1'b1;
        a_req = '0;
        #1;
        chk("t5_bus_en", a_bus_en, 0);
        chk("t5_bus_addr", a_bus_addr, 0);
        chk("t5_ready", a_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a_ack = 1'b1;
        #1 chk("t5_late_ack_ready", a_ready, 0);
        @(negedge clk);
        a_ack = 1'b0;
        chk("t5_after_bus_en", a_bus_en, 0);
        chk("t5_ready_cnt", a_rc[0] - r0, 0);

        // Requester 0 drops its request mid-BUSY; completion still delivered
        a_addr = {32'h0000_0500, 32'h0000_0400};
        a_bus_rd = 32'h600D_CAFE;
        a_req = 2'b11;
        r0 = a_rc[0];
        r1 = a_rc[1];
        push(0, 8'h01, 8'h00, 32'h600D_CAFE, 32'h400);
        push(0, 8'h02, 8'h00, 32'h600D_CAFE, 32'h500);
        @(negedge clk);
        a_req[0] = 1'b0;
        repeat (3) @(negedge clk);
        a_ack = 1'b1;
        wait_ready(0, 1, n);
        @(negedge clk);
        a_ack = 1'b0;
        chk("t6_turnaround", a_bus_en, 0);
        @(negedge clk);
        chk("t6_addr1", a_bus_addr, 32'h500);
        a_ack = 1'b1;
        wait_ready(0, 1, n);
        a_req = '0;
        @(negedge clk);
        a_ack = 1'b0;
        @(negedge clk);
        chk("t6_cnt0", a_rc[0] - r0, 1);
        chk("t6_cnt1", a_rc[1] - r1, 1);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
